// File: rtl/cd_pila_pkg.sv
// -----------------------------------------------------------------------------
// cd_pila_pkg
// Shared definitions for the cd_pila datapath:
//   - instruction word width and field bit positions
//   - ALU operation codes (op_alu)
// -----------------------------------------------------------------------------
package cd_pila_pkg;

    localparam int INSTR_W = 32;

    // Instruction field positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int IMM_HI = 27;
    localparam int IMM_LO = 12;
    localparam int RA1_HI = 11;
    localparam int RA1_LO = 8;
    localparam int RA2_HI = 7;
    localparam int RA2_LO = 4;
    localparam int WA3_HI = 3;
    localparam int WA3_LO = 0;
    localparam int IMM_W  = IMM_HI - IMM_LO + 1;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'b000,
        ALU_NOT_A  = 3'b001,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_NEG_A  = 3'b110,
        ALU_NEG_B  = 3'b111
    } alu_op_e;

endpackage

// File: rtl/cd_pila_alu.sv
// -----------------------------------------------------------------------------
// cd_pila_alu
// Combinational DW-bit ALU.
//   i_a, i_b  : operands
//   i_op      : operation select (alu_op_e encoding)
//   o_res     : result modulo 2^DW
//   o_carry   : carry-out (add), no-borrow (sub), 0 otherwise
//   o_oflow   : two's-complement overflow for add/sub/negate, 0 otherwise
// -----------------------------------------------------------------------------
module cd_pila_alu
    import cd_pila_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [2:0]    i_op,
    output logic [DW-1:0] o_res,
    output logic          o_carry,
    output logic          o_oflow
);

    localparam int M = DW - 1;

    alu_op_e     w_op;
    logic [DW:0] w_sum;
    logic [DW:0] w_diff;

    assign w_op   = alu_op_e'(i_op);
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // Top bit of the extended difference is the borrow.
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_res   = '0;
        o_carry = 1'b0;
        o_oflow = 1'b0;
        case (w_op)
            ALU_PASS_A: o_res = i_a;
            ALU_NOT_A:  o_res = ~i_a;
            ALU_ADD: begin
                o_res   = w_sum[DW-1:0];
                o_carry = w_sum[DW];
                o_oflow = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
            end
            ALU_SUB: begin
                o_res   = w_diff[DW-1:0];
                o_carry = ~w_diff[DW];
                o_oflow = (i_a[M] != i_b[M]) && (w_diff[M] != i_a[M]);
            end
            ALU_AND:    o_res = i_a & i_b;
            ALU_OR:     o_res = i_a | i_b;
            ALU_NEG_A: begin
                o_res   = '0 - i_a;
                // Only the most negative value negates to itself.
                o_oflow = i_a[M] & o_res[M];
            end
            ALU_NEG_B: begin
                o_res   = '0 - i_b;
                o_oflow = i_b[M] & o_res[M];
            end
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/cd_pila_pila_ret.sv
// -----------------------------------------------------------------------------
// pila_ret
// Return-address stack, DEPTH entries of PW bits. The stack pointer counts
// 0..DEPTH and never wraps; pushes when full and pops when empty are ignored
// (the caller decides what to do about them).
//   clk, reset : clock, synchronous active-high reset (clears pointer only)
//   i_push     : push i_data
//   i_pop      : pop top entry (wins if both asserted)
//   o_top      : current top entry (valid when not empty)
//   o_full     : sp == DEPTH
//   o_empty    : sp == 0
// -----------------------------------------------------------------------------
module pila_ret #(
    parameter int DEPTH = 8,
    parameter int PW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [PW-1:0] i_data,
    output logic [PW-1:0] o_top,
    output logic          o_full,
    output logic          o_empty
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);

    logic [PW-1:0]  r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [SPW-1:0] w_sp_dec;
    logic [AW-1:0]  w_wr_idx;
    logic [AW-1:0]  w_rd_idx;
    logic           w_do_push;
    logic           w_do_pop;

    assign w_sp_dec  = r_sp - SPW'(1);
    assign w_wr_idx  = r_sp[AW-1:0];
    assign w_rd_idx  = w_sp_dec[AW-1:0];
    assign o_full    = (r_sp == SPW'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign o_top     = r_mem[w_rd_idx];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !i_pop && !o_full;

    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
        end else if (w_do_pop) begin
            r_sp <= w_sp_dec;
        end else if (w_do_push) begin
            r_sp <= r_sp + SPW'(1);
        end
    end

endmodule

// File: rtl/cd_pila_regfile.sv
// -----------------------------------------------------------------------------
// cd_pila_regfile
// 16 x DW register file, two combinational read ports, one write port.
// R0 always reads zero and writes to it are dropped. Contents are not reset.
//   clk            : clock
//   i_we           : write enable
//   i_ra1, i_ra2   : read addresses
//   i_wa3, i_wd3   : write address / data
//   o_rd1, o_rd2   : read data
// -----------------------------------------------------------------------------
module cd_pila_regfile #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_ra1,
    input  logic [3:0]    i_ra2,
    input  logic [3:0]    i_wa3,
    input  logic [DW-1:0] i_wd3,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2
);

    logic [DW-1:0] r_mem [16];

    always_ff @(posedge clk) begin
        if (i_we && (i_wa3 != 4'd0)) begin
            r_mem[i_wa3] <= i_wd3;
        end
    end

    assign o_rd1 = (i_ra1 == 4'd0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == 4'd0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/cd_pila.sv
// -----------------------------------------------------------------------------
// cd_pila
// Processor datapath with a hardware return-address stack.
//   clk, reset            : clock, synchronous active-high reset
//   s_inc, s_inm, s_datos : next-pc select, immediate operand, external data
//   we3, wez              : register write enable, flag update enable
//   s_call, s_ret         : subroutine call / return (ret wins)
//   op_alu                : ALU operation
//   instruccion           : instruction word at address pc
//   datos                 : external write-back data
//   pc                    : program counter
//   z, c                  : registered zero / carry flags
//   ALUoflow              : combinational signed overflow
//   stk_err               : sticky stack overflow/underflow
//   opcode                : instruccion[31:26]
//   direcciones           : register read port 1 (data address)
// -----------------------------------------------------------------------------
module cd_pila
    import cd_pila_pkg::*;
#(
    parameter int DW    = 16,
    parameter int PW    = 10,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_inc,
    input  logic               s_inm,
    input  logic               s_datos,
    input  logic               we3,
    input  logic               wez,
    input  logic               s_call,
    input  logic               s_ret,
    input  logic [2:0]         op_alu,
    input  logic [INSTR_W-1:0] instruccion,
    input  logic [DW-1:0]      datos,
    output logic [PW-1:0]      pc,
    output logic               z,
    output logic               c,
    output logic               ALUoflow,
    output logic               stk_err,
    output logic [5:0]         opcode,
    output logic [DW-1:0]      direcciones
);

    logic [PW-1:0] r_pc;
    logic          r_z;
    logic          r_c;
    logic          r_stk_err;

    logic [3:0]    w_ra1;
    logic [3:0]    w_ra2;
    logic [3:0]    w_wa3;
    logic [DW-1:0] w_imm;
    logic [PW-1:0] w_target;
    logic [DW-1:0] w_rd1;
    logic [DW-1:0] w_rd2;
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_wd3;
    logic [DW-1:0] w_alu_res;
    logic          w_alu_carry;
    logic          w_alu_oflow;
    logic [PW-1:0] w_pc_inc;
    logic [PW-1:0] w_pc_next;
    logic [PW-1:0] w_stk_top;
    logic          w_stk_full;
    logic          w_stk_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_err_set;

    // Instruction decode
    assign w_ra1    = instruccion[RA1_HI:RA1_LO];
    assign w_ra2    = instruccion[RA2_HI:RA2_LO];
    assign w_wa3    = instruccion[WA3_HI:WA3_LO];
    assign w_target = instruccion[PW-1:0];

    always_comb begin
        w_imm             = '0;
        w_imm[IMM_W-1:0]  = instruccion[IMM_HI:IMM_LO];
    end

    // Register file and ALU
    cd_pila_regfile #(.DW(DW)) u_regfile (
        .clk   (clk),
        .i_we  (we3 & ~reset),
        .i_ra1 (w_ra1),
        .i_ra2 (w_ra2),
        .i_wa3 (w_wa3),
        .i_wd3 (w_wd3),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    assign w_op_a = s_inm ? w_imm : w_rd1;
    assign w_wd3  = s_datos ? datos : w_alu_res;

    cd_pila_alu #(.DW(DW)) u_alu (
        .i_a     (w_op_a),
        .i_b     (w_rd2),
        .i_op    (op_alu),
        .o_res   (w_alu_res),
        .o_carry (w_alu_carry),
        .o_oflow (w_alu_oflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else if (wez) begin
            r_z <= (w_alu_res == '0);
            r_c <= w_alu_carry;
        end
    end

    // Next-pc selection: ret > call > increment > jump.
    // A refused call or return falls through to pc+1 and raises stk_err.
    assign w_pc_inc = r_pc + PW'(1);

    always_comb begin
        w_pc_next = w_target;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (s_ret) begin
            if (!w_stk_empty) begin
                w_pc_next = w_stk_top;
                w_pop     = 1'b1;
            end else begin
                w_pc_next = w_pc_inc;
                w_err_set = 1'b1;
            end
        end else if (s_call) begin
            if (!w_stk_full) begin
                w_pc_next = w_target;
                w_push    = 1'b1;
            end else begin
                w_pc_next = w_pc_inc;
                w_err_set = 1'b1;
            end
        end else if (s_inc) begin
            w_pc_next = w_pc_inc;
        end
    end

    pila_ret #(.DEPTH(DEPTH), .PW(PW)) u_pila (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pc_inc),
        .o_top   (w_stk_top),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_stk_err <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_err_set) begin
                r_stk_err <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign z           = r_z;
    assign c           = r_c;
    assign stk_err     = r_stk_err;
    assign ALUoflow    = w_alu_oflow;
    assign opcode      = instruccion[OPC_HI:OPC_LO];
    assign direcciones = w_rd1;

endmodule

// File: tb/tb_cd_pila.sv
// -----------------------------------------------------------------------------
// tb_cd_pila
// Directed test of cd_pila: pc sequencing, call/return stack, stack error
// cases, ALU/flag behaviour, and pc wrap on a PW=4 instance.
// -----------------------------------------------------------------------------
module tb_cd_pila;

    localparam int DW    = 16;
    localparam int PW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_inc, s_inm, s_datos, we3, wez, s_call, s_ret;
    logic [2:0]    op_alu;
    logic [31:0]   instruccion;
    logic [DW-1:0] datos;

    logic [PW-1:0] pc;
    logic          z, c, ALUoflow, stk_err;
    logic [5:0]    opcode;
    logic [DW-1:0] direcciones;

    logic [3:0]    pc4;
    logic          z4, c4, oflow4, err4;
    logic [5:0]    opcode4;
    logic [DW-1:0] dir4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cd_pila #(.DW(DW), .PW(PW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s_inc(s_inc), .s_inm(s_inm),
        .s_datos(s_datos), .we3(we3), .wez(wez), .s_call(s_call),
        .s_ret(s_ret), .op_alu(op_alu), .instruccion(instruccion),
        .datos(datos), .pc(pc), .z(z), .c(c), .ALUoflow(ALUoflow),
        .stk_err(stk_err), .opcode(opcode), .direcciones(direcciones)
    );

    cd_pila #(.DW(DW), .PW(4), .DEPTH(2)) dut4 (
        .clk(clk), .reset(reset), .s_inc(s_inc), .s_inm(s_inm),
        .s_datos(s_datos), .we3(we3), .wez(wez), .s_call(s_call),
        .s_ret(s_ret), .op_alu(op_alu), .instruccion(instruccion),
        .datos(datos), .pc(pc4), .z(z4), .c(c4), .ALUoflow(oflow4),
        .stk_err(err4), .opcode(opcode4), .direcciones(dir4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_strobes();
        s_inc = 1'b0; s_inm = 1'b0; s_datos = 1'b0; we3 = 1'b0;
        wez = 1'b0; s_call = 1'b0; s_ret = 1'b0; op_alu = 3'd0;
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] ins(input logic [15:0] imm, input logic [3:0] ra1,
                                        input logic [3:0] ra2, input logic [3:0] wa3);
        return {4'h0, imm, ra1, ra2, wa3};
    endfunction

    // ALU write to register wa3, then read it back on direcciones.
    task automatic alu_wr(input string tag, input logic inm, input logic [31:0] ins_w,
                          input logic [2:0] op, input logic [15:0] exp);
        s_inm = inm; op_alu = op; instruccion = ins_w; we3 = 1'b1; wez = 1'b0;
        step();
        we3 = 1'b0; s_inm = 1'b0;
        instruccion = ins(16'h0, ins_w[3:0], 4'h0, 4'h0);
        #1;
        check(tag, 32'(direcciones), 32'(exp));
    endtask

    initial begin
        clr_strobes();
        reset = 1'b1; instruccion = '0; datos = '0;
        step(); step();
        check("rst_pc", 32'(pc), 0);
        check("rst_z", 32'(z), 0);
        check("rst_c", 32'(c), 0);
        check("rst_err", 32'(stk_err), 0);
        check("rst_sp", 32'(dut.u_pila.r_sp), 0);

        // Sequential fetch
        s_inc = 1'b1; reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("inc_pc%0d", i), 32'(pc), 32'(i));
        end
        check("inc_flags", {29'd0, z, c, stk_err}, 0);

        // Call at pc=5 to 0x20, two increments, return to 6
        s_inc = 1'b0; instruccion = 32'h5; step();
        check("jmp_pc", 32'(pc), 32'h5);
        s_call = 1'b1; instruccion = 32'h20; step();
        check("call_pc", 32'(pc), 32'h20);
        check("call_sp", 32'(dut.u_pila.r_sp), 1);
        s_call = 1'b0; s_inc = 1'b1; step();
        check("sub_pc1", 32'(pc), 32'h21);
        step();
        check("sub_pc2", 32'(pc), 32'h22);
        s_ret = 1'b1; step();
        check("ret_pc", 32'(pc), 32'h6);
        check("ret_sp", 32'(dut.u_pila.r_sp), 0);

        // Return with empty stack
        step();
        check("uflow_pc", 32'(pc), 32'h7);
        check("uflow_err", 32'(stk_err), 1);
        s_ret = 1'b0; step();
        check("err_sticky", 32'(stk_err), 1);
        check("err_pc", 32'(pc), 32'h8);
        rst_pulse();
        check("err_clr", 32'(stk_err), 0);

        // call+ret together with one entry: pop only
        s_inc = 1'b0; instruccion = 32'h3; step();
        s_call = 1'b1; instruccion = 32'h40; step();
        check("one_call_pc", 32'(pc), 32'h40);
        s_ret = 1'b1; instruccion = 32'h100; step();
        check("both_pc", 32'(pc), 32'h4);
        check("both_sp", 32'(dut.u_pila.r_sp), 0);
        check("both_err", 32'(stk_err), 0);
        s_ret = 1'b0; s_call = 1'b0;

        // Nested calls: 8 fit, 9th overflows
        rst_pulse();
        instruccion = 32'h10; step();
        s_call = 1'b1;
        for (int k = 0; k < 8; k++) begin
            instruccion = 32'h100 + 32'(16 * k);
            step();
            check($sformatf("nest_call%0d", k), 32'(pc), 32'h100 + 32'(16 * k));
        end
        check("nest_sp8", 32'(dut.u_pila.r_sp), 8);
        check("nest_err0", 32'(stk_err), 0);
        instruccion = 32'h180; step();
        check("oflow_pc", 32'(pc), 32'h171);
        check("oflow_err", 32'(stk_err), 1);
        check("oflow_sp", 32'(dut.u_pila.r_sp), 8);
        s_call = 1'b0; s_ret = 1'b1;
        for (int k = 6; k >= 0; k--) begin
            step();
            check($sformatf("nest_ret%0d", k), 32'(pc), 32'h101 + 32'(16 * k));
        end
        step();
        check("nest_ret_last", 32'(pc), 32'h11);
        check("nest_sp0", 32'(dut.u_pila.r_sp), 0);
        s_ret = 1'b0;

        // Reset in the middle of a call sequence drops the return address
        s_call = 1'b1; instruccion = 32'h200; step();
        s_call = 1'b0; rst_pulse();
        check("midrst_sp", 32'(dut.u_pila.r_sp), 0);
        s_ret = 1'b1; step();
        check("midrst_pc", 32'(pc), 32'h1);
        check("midrst_err", 32'(stk_err), 1);
        s_ret = 1'b0;

        // ALU: load R1..R4 from datos
        rst_pulse();
        s_inc = 1'b1; s_datos = 1'b1; we3 = 1'b1;
        instruccion = 32'h1; datos = 16'h7FFF; step();
        instruccion = 32'h2; datos = 16'h0001; step();
        instruccion = 32'h3; datos = 16'h1234; step();
        instruccion = 32'h4; datos = 16'h1234; step();
        s_datos = 1'b0; we3 = 1'b0;

        // 0x7FFF + 1 -> 0x8000, signed overflow, R5
        instruccion = ins(16'h0, 4'h1, 4'h2, 4'h5); op_alu = 3'b010; wez = 1'b1; we3 = 1'b1;
        #1;
        check("add_oflow", 32'(ALUoflow), 1);
        check("add_rd1", 32'(direcciones), 32'h7FFF);
        step();
        check("add_zc", {30'd0, z, c}, 0);
        wez = 1'b0; we3 = 1'b0;
        instruccion = ins(16'h0, 4'h5, 4'h0, 4'h0); #1;
        check("add_res", 32'(direcciones), 32'h8000);

        // 0x1234 - 0x1234 -> zero, no borrow
        instruccion = ins(16'h0, 4'h3, 4'h4, 4'h0); op_alu = 3'b011; wez = 1'b1; #1;
        check("sub_oflow", 32'(ALUoflow), 0);
        step();
        check("sub_zc", {30'd0, z, c}, 32'h3);

        // Pass A (nonzero) clears z and c
        instruccion = ins(16'h0, 4'h1, 4'h0, 4'h0); op_alu = 3'b000; step();
        check("pass_zc", {30'd0, z, c}, 0);

        // Immediate 0xFFFF + 1 -> 0 with carry, no overflow
        s_inm = 1'b1; instruccion = ins(16'hFFFF, 4'h0, 4'h2, 4'h0); op_alu = 3'b010; #1;
        check("imm_oflow", 32'(ALUoflow), 0);
        step();
        check("imm_zc", {30'd0, z, c}, 32'h3);
        wez = 1'b0;

        // Negate most-negative, and 0x8000 - 1 overflow
        instruccion = ins(16'h8000, 4'h0, 4'h2, 4'h0); op_alu = 3'b110; #1;
        check("nega_oflow", 32'(ALUoflow), 1);
        op_alu = 3'b011; #1;
        check("sub_ovf", 32'(ALUoflow), 1);
        op_alu = 3'b100; #1;
        check("and_noovf", 32'(ALUoflow), 0);
        s_inm = 1'b0;

        alu_wr("negb_res", 1'b0, ins(16'h0, 4'h0, 4'h2, 4'h6), 3'b111, 16'hFFFF);
        alu_wr("not_res",  1'b1, ins(16'h00FF, 4'h0, 4'h0, 4'h7), 3'b001, 16'hFF00);
        alu_wr("and_res",  1'b1, ins(16'h0F0F, 4'h0, 4'h3, 4'h8), 3'b100, 16'h0204);
        alu_wr("or_res",   1'b1, ins(16'h0F0F, 4'h0, 4'h3, 4'h9), 3'b101, 16'h1F3F);

        // R0 ignores writes
        s_datos = 1'b1; we3 = 1'b1; datos = 16'hABCD; instruccion = 32'h0; step();
        s_datos = 1'b0; we3 = 1'b0; #1;
        check("r0_zero", 32'(direcciones), 0);

        instruccion = 32'hA800_0000; #1;
        check("opcode", 32'(opcode), 32'h2A);

        // PW=4 wrap: pc 15 -> 0
        clr_strobes();
        rst_pulse();
        instruccion = 32'hF; step();
        check("pw4_pc15", 32'(pc4), 32'hF);
        s_inc = 1'b1; step();
        check("pw4_wrap", 32'(pc4), 0);
        check("pw10_pc", 32'(pc), 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
